spi_slave_rx_tx: RTL and testbench

Full-duplex SPI slave endpoint that sits directly downstream of the SPI master on the same serial link, consuming SCLK/SS/MOSI and driving MISO back. It oversamples the serial pins in its own system clock domain, deserialises each DATA_WIDTH-bit frame into a small RX FIFO with a valid/ready interface, and serialises a preloaded TX word back to the master in the same frame. It is the device-side model and reusable slave IP for the SPI subsystem, matching mode 0, MSB first, one word per SS-low window.

---
 rtl/spi_slave_rx_tx.sv | 212 +++++++++++++++++++++
 tb/tb_spi_slave_rx_tx.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_rx_tx.sv
// SPI mode-0 slave: oversampled pins, RX FIFO with valid/ready, staged TX word shifted out MSB first.
// Build option SPI_SLAVE_ECHO_EN: unstaged frames send back the last word pushed into the RX FIFO.
module spi_slave_rx_tx #(
    parameter int unsigned           DATA_WIDTH = 8,
    parameter int unsigned           FIFO_DEPTH = 4,
    parameter logic [DATA_WIDTH-1:0] IDLE_WORD  = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  sclk,
    input  logic                  ss,
    input  logic                  mosi,
    output logic                  miso,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_valid,
    output logic                  tx_ready,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  busy,
    output logic                  rx_overflow,
    output logic                  frame_abort
);

    localparam int unsigned AW   = $clog2(FIFO_DEPTH);
    localparam int unsigned CNTW = AW + 1;
    localparam int unsigned CW   = $clog2(DATA_WIDTH + 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e                state_q, state_d;
    logic [2:0]            sclk_sync_q, sclk_sync_d;
    logic [2:0]            ss_sync_q, ss_sync_d;
    logic [1:0]            mosi_sync_q, mosi_sync_d;
    logic [1:0]            settle_q, settle_d;
    logic                  armed_q, armed_d;
    logic [DATA_WIDTH-1:0] shift_tx_q, shift_tx_d;
    logic [DATA_WIDTH-1:0] shift_rx_q, shift_rx_d;
    logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  hold_full_q, hold_full_d;
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNTW-1:0]       count_q, count_d;
    logic                  ovf_q, ovf_d, abort_q, abort_d;
    logic                  sclk_rise, sclk_fall, ss_fall, ss_rise;
    logic                  push, pop, full, push_ok;
    logic [DATA_WIDTH-1:0] fallback_word;
`ifdef SPI_SLAVE_ECHO_EN
    logic [DATA_WIDTH-1:0] echo_q, echo_d;
`endif

    assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall = ~sclk_sync_q[1] & sclk_sync_q[2];
    assign ss_fall   = ~ss_sync_q[1] & ss_sync_q[2];
    assign ss_rise   = ss_sync_q[1] & ~ss_sync_q[2];

`ifdef SPI_SLAVE_ECHO_EN
    assign fallback_word = echo_q;
`else
    assign fallback_word = IDLE_WORD;
`endif

    always_comb begin
        sclk_sync_d = {sclk_sync_q[1:0], sclk};
        ss_sync_d   = {ss_sync_q[1:0], ss};
        mosi_sync_d = {mosi_sync_q[0], mosi};
        // Only arm after the freshly reset synchroniser has seen ss genuinely high,
        // so a reset released mid-frame cannot fake an ss falling edge.
        settle_d    = (settle_q == 2'd3) ? settle_q : settle_q + 2'd1;
        armed_d     = armed_q | ((settle_q == 2'd3) & ss_sync_q[1]);
        state_d     = state_q;
        shift_tx_d  = shift_tx_q;
        shift_rx_d  = shift_rx_q;
        bit_cnt_d   = bit_cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        abort_d     = 1'b0;
        push        = 1'b0;

        if (tx_valid && !hold_full_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (ss_fall && armed_q) begin
                    state_d    = StShift;
                    bit_cnt_d  = '0;
                    shift_rx_d = '0;
                    if (hold_full_q) begin
                        shift_tx_d  = hold_q;
                        hold_full_d = 1'b0;
                    end else begin
                        shift_tx_d = fallback_word;
                    end
                end
            end
            StShift: begin
                if (bit_cnt_q == CW'(DATA_WIDTH)) begin
                    push    = 1'b1;
                    state_d = StDone;
                end else if (ss_rise) begin
                    state_d = StIdle;
                    abort_d = (bit_cnt_q != '0);
                end else begin
                    if (sclk_rise) begin
                        shift_rx_d = {shift_rx_q[DATA_WIDTH-2:0], mosi_sync_q[1]};
                        bit_cnt_d  = bit_cnt_q + CW'(1);
                    end
                    if (sclk_fall) begin
                        shift_tx_d = {shift_tx_q[DATA_WIDTH-2:0], 1'b0};
                    end
                end
            end
            StDone: begin
                if (ss_rise) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // RX FIFO: a pop frees the slot in the same cycle, so push-while-full succeeds when popping.
    assign pop     = (count_q != '0) & rx_ready;
    assign full    = (count_q == CNTW'(FIFO_DEPTH));
    assign push_ok = push & (~full | pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = push & full & ~pop;
`ifdef SPI_SLAVE_ECHO_EN
        echo_d   = echo_q;
`endif
        if (push_ok) begin
            mem_d[wr_ptr_q] = shift_rx_q;
            wr_ptr_d        = wr_ptr_q + AW'(1);
`ifdef SPI_SLAVE_ECHO_EN
            echo_d          = shift_rx_q;
`endif
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            sclk_sync_q <= 3'b000;
            ss_sync_q   <= 3'b111;
            mosi_sync_q <= 2'b00;
            settle_q    <= 2'd0;
            armed_q     <= 1'b0;
            shift_tx_q  <= '0;
            shift_rx_q  <= '0;
            bit_cnt_q   <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            mem_q       <= '{default: '0};
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            abort_q     <= 1'b0;
`ifdef SPI_SLAVE_ECHO_EN
            echo_q      <= IDLE_WORD;
`endif
        end else begin
            state_q     <= state_d;
            sclk_sync_q <= sclk_sync_d;
            ss_sync_q   <= ss_sync_d;
            mosi_sync_q <= mosi_sync_d;
            settle_q    <= settle_d;
            armed_q     <= armed_d;
            shift_tx_q  <= shift_tx_d;
            shift_rx_q  <= shift_rx_d;
            bit_cnt_q   <= bit_cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            abort_q     <= abort_d;
`ifdef SPI_SLAVE_ECHO_EN
            echo_q      <= echo_d;
`endif
        end
    end

    assign miso        = (state_q != StIdle) && shift_tx_q[DATA_WIDTH-1];
    assign tx_ready    = ~hold_full_q;
    assign rx_data     = mem_q[rd_ptr_q];
    assign rx_valid    = (count_q != '0);
    assign busy        = (state_q != StIdle);
    assign rx_overflow = ovf_q;
    assign frame_abort = abort_q;

endmodule

// File: tb/tb_spi_slave_rx_tx.sv
// Scoreboard bench for spi_slave_rx_tx: a mode-0 master model drives frames and
// expected RX words / MISO words come from a small bench-side model.
module tb_spi_slave_rx_tx;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 4;
    localparam logic [7:0]  IDLE  = 8'h00;

    logic          clk = 1'b0;
    logic          rst_n, sclk, ss, mosi, miso;
    logic [DW-1:0] tx_data, rx_data;
    logic          tx_valid, tx_ready, rx_valid, rx_ready, busy, rx_overflow, frame_abort;

    spi_slave_rx_tx #(
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(DEPTH),
        .IDLE_WORD (IDLE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sclk       (sclk),
        .ss         (ss),
        .mosi       (mosi),
        .miso       (miso),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .busy       (busy),
        .rx_overflow(rx_overflow),
        .frame_abort(frame_abort)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int ovf_cnt  = 0;
    int abort_cnt = 0;

    logic [7:0] exp_q[$];
    logic [7:0] last_pushed = IDLE;
    logic [7:0] staged      = 8'h00;
    bit         staged_v    = 1'b0;

    always @(negedge clk) begin
        if (rx_overflow) ovf_cnt++;
        if (frame_abort) abort_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] miso_expect();
        if (staged_v) return staged;
`ifdef SPI_SLAVE_ECHO_EN
        return last_pushed;
`else
        return IDLE;
`endif
    endfunction

    task automatic model_push(input logic [7:0] w);
        if (exp_q.size() < DEPTH) begin
            exp_q.push_back(w);
            last_pushed = w;
        end
    endtask

    task automatic stage(input logic [7:0] w);
        @(negedge clk);
        check_eq("tx_ready_idle", tx_ready, 1);
        tx_data  = w;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        staged   = w;
        staged_v = 1'b1;
        check_eq("tx_ready_staged", tx_ready, 0);
    endtask

    // Mode-0 master, 4 clk per SCLK phase; optional one-cycle pop aligned with the final push.
    task automatic frame(input logic [7:0] w, input int nbits, input bit pop_at_push,
                         output logic [7:0] got);
        logic [7:0] r;
        logic [7:0] e;
        r = 8'h00;
        @(negedge clk);
        mosi = w[7];
        ss   = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("busy_in_frame", busy, 1);
        for (int i = 0; i < nbits; i++) begin
            r[7-i] = miso;
            sclk   = 1'b1;
            if (pop_at_push && i == nbits - 1) begin
                repeat (3) @(negedge clk);
                e = exp_q.pop_front();
                check_eq("pop_head", rx_data, e);
                rx_ready = 1'b1;
                @(negedge clk);
                rx_ready = 1'b0;
            end else begin
                repeat (4) @(negedge clk);
            end
            sclk = 1'b0;
            if (i < 7) mosi = w[6-i];
            repeat (4) @(negedge clk);
        end
        ss = 1'b1;
        repeat (6) @(negedge clk);
        check_eq("busy_after_frame", busy, 0);
        got = r;
    endtask

    task automatic do_frame(input logic [7:0] w, input int nbits, input bit pop_at_push);
        logic [7:0] exp_m;
        logic [7:0] got;
        exp_m = miso_expect();
        frame(w, nbits, pop_at_push, got);
        staged_v = 1'b0;
        if (nbits == 8) begin
            check_eq("miso_word", got, exp_m);
            model_push(w);
        end
    endtask

    task automatic drain();
        int n;
        int want;
        logic [31:0] e;
        n    = 0;
        want = exp_q.size();
        @(negedge clk);
        rx_ready = 1'b1;
        for (int k = 0; k < DEPTH + 4; k++) begin
            if (!rx_valid) break;
            e = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'h100;
            check_eq("rx_data", rx_data, e);
            n++;
            @(negedge clk);
        end
        rx_ready = 1'b0;
        check_eq("drain_count", n, want);
    endtask

    initial begin
        int o0;
        int a0;
        rst_n    = 1'b0;
        ss       = 1'b1;
        sclk     = 1'b0;
        mosi     = 1'b0;
        tx_data  = '0;
        tx_valid = 1'b0;
        rx_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_miso", miso, 0);
        check_eq("rst_tx_ready", tx_ready, 1);
        check_eq("rst_rx_valid", rx_valid, 0);
        check_eq("rst_rx_data", rx_data, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_overflow", rx_overflow, 0);
        check_eq("rst_abort", frame_abort, 0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        // Staged TX word, then an unstaged frame
        stage(8'hA5);
        do_frame(8'h3C, 8, 1'b0);
        check_eq("tx_ready_return", tx_ready, 1);
        drain();
        do_frame(8'h81, 8, 1'b0);
        drain();

        // Overflow on the fifth frame
        o0 = ovf_cnt;
        for (int i = 1; i <= 5; i++) do_frame(8'(i), 8, 1'b0);
        check_eq("overflow_pulses", ovf_cnt - o0, 1);
        drain();
        check_eq("empty_after_drain", rx_valid, 0);

        // Aborted frame, then a clean one
        a0 = abort_cnt;
        do_frame(8'hFF, 3, 1'b0);
        check_eq("abort_pulses", abort_cnt - a0, 1);
        check_eq("abort_no_push", rx_valid, 0);
        do_frame(8'h5A, 8, 1'b0);
        drain();

        // Push while full with a simultaneous pop
        for (int i = 0; i < 4; i++) do_frame(8'h10 + 8'(i), 8, 1'b0);
        o0 = ovf_cnt;
        do_frame(8'h14, 8, 1'b1);
        check_eq("full_pop_push_no_ovf", ovf_cnt - o0, 0);
        drain();

        // Reset mid-frame with ss still low afterwards
        @(negedge clk);
        mosi = 1'b1;
        ss   = 1'b0;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            sclk = 1'b1; repeat (4) @(negedge clk);
            sclk = 1'b0; repeat (4) @(negedge clk);
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        last_pushed = IDLE;
        staged_v    = 1'b0;
        a0 = abort_cnt;
        for (int i = 0; i < 8; i++) begin
            sclk = 1'b1; repeat (4) @(negedge clk);
            sclk = 1'b0; repeat (4) @(negedge clk);
        end
        check_eq("post_rst_busy", busy, 0);
        check_eq("post_rst_no_push", rx_valid, 0);
        check_eq("post_rst_no_abort", abort_cnt - a0, 0);
        ss = 1'b1;
        repeat (6) @(negedge clk);
        do_frame(8'hC3, 8, 1'b0);
        drain();

        // Unstaged frame after 0x77: echo returns it, otherwise idle word
        do_frame(8'h77, 8, 1'b0);
        drain();
        do_frame(8'h2E, 8, 1'b0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
